// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO plus issue/wait/capture FSM in front of the 4-bit accumulator ALU
// Optional ALU_SEQ_STATS_EN adds a saturating overflow counter (ovf_cnt) with synchronous clear (stats_clr).

module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                     Clk,
  input  logic                     nReset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [3:0]               cmd_a,
  input  logic [3:0]               cmd_b,
  input  logic [3:0]               cmd_m,
  input  logic                     cmd_cin,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [3:0]               alu_m,
  output logic                     alu_cin,
  input  logic [3:0]               alu_r,
  input  logic                     alu_of,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [3:0]               res_r,
  output logic                     res_of,
  output logic [3:0]               res_m,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [7:0]               ovf_cnt,
  input  logic                     stats_clr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t        state;
  logic [LW-1:0] wcnt;
  logic [12:0]   mem [DEPTH];
  logic [12:0]   head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          capture;

  assign cmd_ready = (count < CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_IDLE) && (count != '0);
  assign busy      = (state != S_IDLE) || (count != '0);
  assign head      = mem[rd_ptr];
  assign capture   = (state == S_WAIT) && (wcnt == '0);

  // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_m, cmd_cin};
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // alu_* only move on issue so the ALU keeps seeing the last command until the next one.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      wcnt      <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_m     <= '0;
      alu_cin   <= 1'b0;
      res_valid <= 1'b0;
      res_r     <= '0;
      res_of    <= 1'b0;
      res_m     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            {alu_a, alu_b, alu_m, alu_cin} <= head;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wcnt  <= LW'(ALU_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            res_r     <= alu_r;
            res_of    <= alu_of;
            res_m     <= alu_m;
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end else begin
            wcnt <= wcnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      ovf_cnt <= '0;
    end else if (stats_clr) begin
      ovf_cnt <= '0;
    end else if (capture && alu_of && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized self-checking bench for alu_cmd_sequencer with a behavioural ALU
// Builds ALU_SEQ_STATS_EN checks only when that macro is defined.

module tb_alu_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] m;
    logic       cin;
  } cmd_t;

  logic                   Clk;
  logic                   nReset;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [3:0]             cmd_a, cmd_b, cmd_m;
  logic                   cmd_cin;
  logic [3:0]             alu_a, alu_b, alu_m;
  logic                   alu_cin;
  logic [3:0]             alu_r;
  logic                   alu_of;
  logic                   res_valid;
  logic                   res_ready;
  logic [3:0]             res_r;
  logic                   res_of;
  logic [3:0]             res_m;
  logic                   busy;
  logic [$clog2(DEPTH):0] count;
`ifdef ALU_SEQ_STATS_EN
  logic [7:0]             ovf_cnt;
  logic                   stats_clr;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_res    = 0;
  bit   done;
  cmd_t exp_q[$];
  cmd_t mon_e;
  logic [4:0] mon_x;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .Clk(Clk), .nReset(nReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_m(cmd_m), .cmd_cin(cmd_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_r(alu_r), .alu_of(alu_of),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_of(res_of), .res_m(res_m),
    .busy(busy), .count(count)
`ifdef ALU_SEQ_STATS_EN
    , .ovf_cnt(ovf_cnt), .stats_clr(stats_clr)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural ALU: returns {flag, result}; flag is carry for add, borrow for sub.
  function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                       input logic [3:0] m, input logic c);
    logic [4:0] s;
    case (m)
      4'd0:    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
      4'd1:    s = {1'b0, a} - {1'b0, b};
      4'd2:    s = {1'b0, a & b};
      4'd3:    s = {1'b0, a | b};
      4'd4:    s = {1'b0, a ^ b};
      default: s = {1'b0, a};
    endcase
    return s;
  endfunction

  always @(posedge Clk) {alu_of, alu_r} <= alu_f(alu_a, alu_b, alu_m, alu_cin);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard: accepted commands queue up; each returned result must match the oldest one.
  always @(negedge Clk) begin
    if (!nReset) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) exp_q.push_back('{cmd_a, cmd_b, cmd_m, cmd_cin});
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("res_unexpected", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_x = alu_f(mon_e.a, mon_e.b, mon_e.m, mon_e.cin);
          check("res_r", res_r, mon_x[3:0]);
          check("res_of", res_of, mon_x[4]);
          check("res_m", res_m, mon_e.m);
          n_res++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the command.
  task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] m, input logic c);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_m = m; cmd_cin = c;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) check("push_timeout", 0, 1);
    else begin @(posedge Clk); #1; end
    cmd_valid = 1'b0;
  endtask

  task automatic push_rand();
    push_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
  endtask

  task automatic wait_res();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      if (res_valid) begin ok = 1; break; end
    end
    if (!ok) check("res_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (!busy) break;
    end
    check("idle_timeout", busy, 0);
  endtask

  initial begin
    int   base;
    bit   stale;
    cmd_t b_cmd;
    nReset = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_m = '0; cmd_cin = 1'b0; done = 0;
`ifdef ALU_SEQ_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("reset_idle", {cmd_ready, count, busy, res_valid, res_r, res_of, res_m,
                           alu_a, alu_b, alu_m, alu_cin}, {1'b1, 27'd0});
    end

    // Single add: latency and captured values.
    @(posedge Clk); #1;
    push_cmd(4'b1010, 4'b0101, 4'b0000, 1'b0);
    @(negedge Clk); check("add_count", count, 1);
    @(negedge Clk); check("add_issue", {alu_a, alu_b, alu_m, alu_cin}, {4'b1010, 4'b0101, 4'b0000, 1'b0});
    repeat (ALU_LAT) @(negedge Clk);
    check("add_early", res_valid, 0);
    @(negedge Clk);
    check("add_valid", res_valid, 1);
    check("add_r", res_r, 4'b1111);
    check("add_of", res_of, 0);
    check("add_m", res_m, 4'b0000);
    @(posedge Clk); #1 res_ready = 1'b1;
    @(posedge Clk); #1 res_ready = 1'b0;
    @(negedge Clk);
    check("add_release", res_valid, 0);
    check("add_res_held", res_r, 4'b1111);

    // Carry out; res_ready already high before the result exists.
    @(posedge Clk); #1 res_ready = 1'b1;
    push_cmd(4'b1111, 4'b0001, 4'b0000, 1'b0);
    wait_res();
    check("carry_r", res_r, 4'b0000);
    check("carry_of", res_of, 1);
    @(posedge Clk); #1 res_ready = 1'b0;

    // Backpressure: one in flight plus a full FIFO.
    base = n_res;
    for (int i = 0; i < 5; i++) push_rand();
    @(negedge Clk);
    check("bp_count", count, DEPTH);
    check("bp_ready", cmd_ready, 0);
    check("bp_valid", res_valid, 1);
    @(posedge Clk); #1;
    fork
      push_rand();
      begin repeat (2) @(posedge Clk); #1 res_ready = 1'b1; end
    join
    wait_idle();
    check("bp_results", n_res - base, 6);
    res_ready = 1'b0;

    // Push and pop on the same edge with count = 2.
    @(posedge Clk); #1;
    push_rand();
    b_cmd = '{4'h6, 4'h3, 4'h1, 1'b0};
    push_cmd(b_cmd.a, b_cmd.b, b_cmd.m, b_cmd.cin);
    push_rand();
    wait_res();
    @(posedge Clk); #1 res_ready = 1'b1;
    @(posedge Clk); #1 res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 4'h9; cmd_b = 4'h9; cmd_m = 4'h0; cmd_cin = 1'b1;
    @(negedge Clk); check("pp_before", count, 2);
    @(posedge Clk); #1 cmd_valid = 1'b0;
    @(negedge Clk);
    check("pp_after", count, 2);
    check("pp_issue", {alu_a, alu_b, alu_m, alu_cin}, b_cmd);
    res_ready = 1'b1;
    wait_idle();

    // Random stream of 20 against random consumer backpressure.
    base = n_res;
    done = 0;
    @(posedge Clk); #1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
          push_rand();
        end
        done = 1;
      end
      begin
        for (int i = 0; i < 3000 && !done; i++) begin
          @(posedge Clk); #1 res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    wait_idle();
    check("stream_results", n_res - base, 20);
    check("stream_left", exp_q.size(), 0);

    // Reset while a command is in WAIT with three queued.
    res_ready = 1'b0;
    @(posedge Clk); #1;
    push_rand();
    wait_res();
    @(posedge Clk); #1;
    for (int i = 0; i < 4; i++) push_rand();
    res_ready = 1'b1;
    @(posedge Clk); #1 res_ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("mid_count", count, 3);
    @(negedge Clk);
    check("mid_wait", {res_valid, count}, {1'b0, 3'd3});
    #2 nReset = 1'b0;
    #1;
    check("rst_count", count, 0);
    check("rst_valid", res_valid, 0);
    check("rst_alu", {alu_a, alu_b, alu_m, alu_cin}, 0);
    check("rst_ready", cmd_ready, 1);
    repeat (2) @(posedge Clk);
    #3 nReset = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      stale |= res_valid;
    end
    check("no_stale", stale, 0);
    check("rst_queue", exp_q.size(), 0);
    base = n_res;
    res_ready = 1'b1;
    @(posedge Clk); #1;
    push_cmd(4'h3, 4'h4, 4'h0, 1'b1);
    wait_idle();
    check("post_rst_result", n_res - base, 1);

`ifdef ALU_SEQ_STATS_EN
    @(posedge Clk); #1 stats_clr = 1'b1;
    @(posedge Clk); #1 stats_clr = 1'b0;
    push_cmd(4'hF, 4'h1, 4'h0, 1'b0);
    push_cmd(4'h1, 4'h1, 4'h0, 1'b0);
    push_cmd(4'hF, 4'hF, 4'h0, 1'b0);
    push_cmd(4'h2, 4'h3, 4'h0, 1'b0);
    push_cmd(4'h8, 4'h8, 4'h0, 1'b0);
    wait_idle();
    check("ovf_three", ovf_cnt, 3);
    @(posedge Clk); #1 stats_clr = 1'b1;
    @(posedge Clk); #1 stats_clr = 1'b0;
    @(negedge Clk); check("ovf_clear", ovf_cnt, 0);
    @(posedge Clk); #1;
    for (int i = 0; i < 300; i++) push_cmd(4'hF, 4'h1, 4'h0, 1'b0);
    wait_idle();
    check("ovf_saturate", ovf_cnt, 255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
